// File: rtl/axis_fifo_thresh_if.sv
// AXI-Stream channel bundle used for both sides of axis_fifo_thresh.
// The master drives data/valid, and the slave drives ready.
interface axis_fifo_thresh_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] TDATA;
    logic             TVALID;
    logic             TREADY;

    modport master (output TDATA, output TVALID, input TREADY);
    modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/axis_fifo_thresh.sv
// First-word fall-through AXI-Stream FIFO with occupancy, high-water mark and
// almost-full/almost-empty flags; supports non-power-of-two depths.
module axis_fifo_thresh #(
    parameter int WIDTH     = 24,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  flush,
    input  logic                  clear_max,
    axis_fifo_thresh_if.slave     in0_V_V,
    axis_fifo_thresh_if.master    out_V_V,
    output logic [CW-1:0]         count,
    output logic [CW-1:0]         max_count,
    output logic                  almost_full,
    output logic                  almost_empty
);
    localparam int            PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C  = CW'(AEMPTY_TH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_max;
    logic             r_not_full;
    logic             r_valid;
    logic             r_afull;
    logic             r_aempty;

    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_max_nxt;
    logic             w_tready;
    logic             w_wr;
    logic             w_rd;

    // r_not_full resets low, so ready cannot rise before the first edge after reset.
    assign w_tready = r_not_full & ~flush;
    assign w_wr     = in0_V_V.TVALID & w_tready;
    assign w_rd     = r_valid & out_V_V.TREADY & ~flush;

    // Next pointers and occupancy; flush overrides any transfer in the same cycle.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_cnt_nxt    = r_count;
        if (flush) begin
            w_wr_ptr_nxt = {PW{1'b0}};
            w_rd_ptr_nxt = {PW{1'b0}};
            w_cnt_nxt    = {CW{1'b0}};
        end else begin
            if (w_wr) begin
                w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? {PW{1'b0}} : r_wr_ptr + PW'(1);
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
            end
            if (w_rd) begin
                w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? {PW{1'b0}} : r_rd_ptr + PW'(1);
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
            end
            case ({w_wr, w_rd})
                2'b10:   w_cnt_nxt = r_count + CW'(1);
                2'b01:   w_cnt_nxt = r_count - CW'(1);
                default: w_cnt_nxt = r_count;
            endcase
        end
    end

    // High-water mark tracks the post-update occupancy; clear_max reloads it.
    always_comb begin
        w_max_nxt = r_max;
        if (clear_max) begin
            w_max_nxt = w_cnt_nxt;
        end else if (w_cnt_nxt > r_max) begin
            w_max_nxt = w_cnt_nxt;
        end else begin
            w_max_nxt = r_max;
        end
    end

    // Control state and status flags, registered from the next occupancy.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_wr_ptr   <= {PW{1'b0}};
            r_rd_ptr   <= {PW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_max      <= {CW{1'b0}};
            r_not_full <= 1'b0;
            r_valid    <= 1'b0;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_cnt_nxt;
            r_max      <= w_max_nxt;
            r_not_full <= (w_cnt_nxt < DEPTH_C);
            r_valid    <= (w_cnt_nxt != {CW{1'b0}});
            r_afull    <= (w_cnt_nxt >= AFULL_C);
            r_aempty   <= (w_cnt_nxt <= AEMPTY_C);
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge ap_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in0_V_V.TDATA;
        end
    end

    assign in0_V_V.TREADY = w_tready;
    assign out_V_V.TVALID = r_valid;
    assign out_V_V.TDATA  = r_mem[r_rd_ptr];
    assign count          = r_count;
    assign max_count      = r_max;
    assign almost_full    = r_afull;
    assign almost_empty   = r_aempty;
endmodule

// File: tb/tb_axis_fifo_thresh.sv
// Scoreboard bench for axis_fifo_thresh: directed fill/drain, full-with-read,
// streaming wrap, flush/clear_max and mid-cycle asynchronous reset.
module tb_axis_fifo_thresh;
    logic       ap_clk = 1'b0;
    logic       ap_rst = 1'b0;
    logic       flush = 1'b0;
    logic       clear_max = 1'b0;
    logic [4:0] count;
    logic [4:0] max_count;
    logic       almost_full;
    logic       almost_empty;

    axis_fifo_thresh_if #(.WIDTH(24)) in_if ();
    axis_fifo_thresh_if #(.WIDTH(24)) out_if ();

    axis_fifo_thresh #(
        .WIDTH(24), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(2)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .flush        (flush),
        .clear_max    (clear_max),
        .in0_V_V      (in_if),
        .out_V_V      (out_if),
        .count        (count),
        .max_count    (max_count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 ap_clk = ~ap_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Monitor: pop/compare on output handshakes first, then record accepted inputs.
    always @(negedge ap_clk) begin
        logic [23:0] exp_d;
        if (!ap_rst && !flush && out_if.TVALID && out_if.TREADY) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL out_unexpected: got 0x%0h expected no word", out_if.TDATA);
            end else begin
                exp_d = sb_q.pop_front();
                chk("out_data", {8'h00, out_if.TDATA}, {8'h00, exp_d});
            end
        end
        if (!ap_rst && in_if.TVALID && in_if.TREADY) begin
            sb_q.push_back(in_if.TDATA);
        end
    end

    initial begin
        int sent;
        int cyc;
        in_if.TVALID  = 1'b0;
        in_if.TDATA   = 24'h0;
        out_if.TREADY = 1'b0;

        // Reset values
        #1 ap_rst = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_max", max_count, 0);
        chk("rst_tvalid", out_if.TVALID, 0);
        chk("rst_tready", in_if.TREADY, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_aempty", almost_empty, 1);
        repeat (3) step();
        ap_rst = 1'b0;
        #1 chk("tready_before_edge", in_if.TREADY, 0);
        step();
        chk("tready_after_edge", in_if.TREADY, 1);

        // Fill 1..16 with output stalled
        for (int k = 1; k <= 16; k++) begin
            in_if.TVALID = 1'b1;
            in_if.TDATA  = 24'(k);
            step();
            chk("fill_count", count, 32'(k));
            chk("fill_afull", almost_full, (k >= 12) ? 1 : 0);
            chk("fill_aempty", almost_empty, (k <= 2) ? 1 : 0);
            chk("fill_tready", in_if.TREADY, (k < 16) ? 1 : 0);
        end
        chk("fill_max", max_count, 16);
        chk("fill_head", {8'h00, out_if.TDATA}, 32'h1);

        // Full with simultaneous read: no write admitted
        in_if.TDATA   = 24'h000077;
        out_if.TREADY = 1'b1;
        step();
        in_if.TVALID = 1'b0;
        chk("fullrd_count", count, 15);
        chk("fullrd_max", max_count, 16);

        // Drain remaining 15
        for (int k = 15; k >= 1; k--) begin
            step();
            chk("drain_count", count, 32'(k - 1));
            chk("drain_aempty", almost_empty, ((k - 1) <= 2) ? 1 : 0);
        end
        chk("drain_tvalid", out_if.TVALID, 0);
        out_if.TREADY = 1'b0;

        clear_max = 1'b1;
        step();
        clear_max = 1'b0;
        chk("clrmax_empty", max_count, 0);

        // Streaming with random stalls; pointers wrap
        sent = 0;
        cyc  = 0;
        while ((sent < 40 || sb_q.size() != 0) && cyc < 2000) begin
            in_if.TVALID  = (sent < 40) && ($urandom_range(0, 3) != 0);
            in_if.TDATA   = 24'h000100 + 24'(sent);
            out_if.TREADY = ($urandom_range(0, 2) != 0);
            @(negedge ap_clk);
            if (in_if.TVALID && in_if.TREADY) sent++;
            step();
            cyc++;
        end
        chk("wrap_done", (cyc < 2000) ? 1 : 0, 1);
        in_if.TVALID  = 1'b0;
        out_if.TREADY = 1'b0;
        step();
        chk("wrap_count", count, 0);
        chk("wrap_max_le_depth", (max_count <= 5'd16) ? 1 : 0, 1);

        // Flush with 9 stored
        clear_max = 1'b1;
        step();
        clear_max = 1'b0;
        chk("clrmax_pre_flush", max_count, 0);
        for (int k = 1; k <= 9; k++) begin
            in_if.TVALID = 1'b1;
            in_if.TDATA  = 24'h000200 + 24'(k);
            step();
        end
        chk("flush_pre_count", count, 9);
        chk("flush_pre_max", max_count, 9);
        flush = 1'b1;
        sb_q.delete();
        #1 chk("flush_tready", in_if.TREADY, 0);
        step();
        flush        = 1'b0;
        in_if.TVALID = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_tvalid", out_if.TVALID, 0);
        chk("flush_max_kept", max_count, 9);
        clear_max = 1'b1;
        step();
        clear_max = 1'b0;
        chk("flush_clrmax", max_count, 0);

        // Flush and clear_max together
        for (int k = 1; k <= 3; k++) begin
            in_if.TVALID = 1'b1;
            in_if.TDATA  = 24'h000250 + 24'(k);
            step();
        end
        in_if.TVALID = 1'b0;
        chk("fc_pre_max", max_count, 3);
        flush     = 1'b1;
        clear_max = 1'b1;
        sb_q.delete();
        step();
        flush     = 1'b0;
        clear_max = 1'b0;
        chk("fc_count", count, 0);
        chk("fc_max", max_count, 0);

        // Asynchronous reset between edges during a burst
        out_if.TREADY = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_if.TVALID = 1'b1;
            in_if.TDATA  = 24'h000300 + 24'(k);
            step();
        end
        chk("ar_pre_count", count, 4);
        #2 ap_rst = 1'b1;
        sb_q.delete();
        #1;
        chk("ar_count", count, 0);
        chk("ar_max", max_count, 0);
        chk("ar_tvalid", out_if.TVALID, 0);
        chk("ar_tready", in_if.TREADY, 0);
        chk("ar_afull", almost_full, 0);
        chk("ar_aempty", almost_empty, 1);
        step();
        ap_rst = 1'b0;
        #1 chk("ar_tready_pre_edge", in_if.TREADY, 0);
        step();
        chk("ar_tready_post_edge", in_if.TREADY, 1);
        chk("ar_no_survivor", count, 0);
        chk("ar_tvalid_post", out_if.TVALID, 0);

        // Post-reset traffic
        out_if.TREADY = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            in_if.TDATA = 24'h000400 + 24'(k);
            step();
        end
        in_if.TVALID = 1'b0;
        repeat (4) step();
        chk("end_count", count, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axis_fifo_thresh.md
AXIS_FIFO_THRESH -- requirements
Module: axis_fifo_thresh

Interface
REQ-001 Parameter WIDTH, default 24, stream data width in bits (>=1) SHALL be supported.
REQ-002 Parameter DEPTH, default 16, number of storage entries (>=2, not required to be a power of two) SHALL be supported.
REQ-003 Parameter AFULL_TH, default 12, almost-full threshold in entries (1..DEPTH) SHALL be supported.
REQ-004 Parameter AEMPTY_TH, default 2, almost-empty threshold in entries (0..DEPTH-1) SHALL be supported.
REQ-005 Derived width CW = clog2(DEPTH+1) SHALL size all occupancy outputs.
REQ-006 ap_clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 ap_rst  input  1  asynchronous, active-high reset.
REQ-008 flush  input  1  synchronous discard of all stored words.
REQ-009 clear_max  input  1  synchronous reload of the high-water mark.
REQ-010 in0_V_V_TDATA / TVALID / TREADY  input / input / output  WIDTH / 1 / 1  AXI-Stream slave.
REQ-011 out_V_V_TDATA / TVALID / TREADY  output / output / input  WIDTH / 1 / 1  AXI-Stream master.
REQ-012 count  output  CW  current occupancy.
REQ-013 max_count  output  CW  high-water mark of occupancy.
REQ-014 almost_full, almost_empty  output  1 each  threshold flags.

Function
REQ-015 Write SHALL occur when in0_V_V_TVALID and in0_V_V_TREADY are both 1; read SHALL occur when out_V_V_TVALID and out_V_V_TREADY are both 1.
REQ-016 in0_V_V_TREADY SHALL be (count < DEPTH) and not flush, with no combinational path from out_V_V_TREADY.
REQ-017 out_V_V_TVALID SHALL be (count != 0); out_V_V_TDATA SHALL present the oldest stored word (first-word fall-through).
REQ-018 Latency: a word accepted in cycle N SHALL be presented on the output in cycle N+1 at the earliest; no same-cycle input-to-output bypass.
REQ-019 Order SHALL be strictly FIFO; no word SHALL be dropped, duplicated or reordered.
REQ-020 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 count SHALL update as +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-022 Full (count = DEPTH): TREADY low; a read in that cycle SHALL NOT admit a write in the same cycle.
REQ-023 Empty (count = 0): TVALID low; out_V_V_TDATA is don't-care.
REQ-024 out_V_V_TDATA and out_V_V_TVALID SHALL remain stable while TVALID=1 and TREADY=0.
REQ-025 flush=1 SHALL set count and both pointers to 0 on the next edge; writes and reads in that cycle SHALL be ignored; stored data is discarded.
REQ-026 almost_full SHALL equal (count >= AFULL_TH); almost_empty SHALL equal (count <= AEMPTY_TH); both decoded from registered count only.
REQ-027 max_count SHALL load max(max_count, next count) each cycle.
REQ-028 clear_max=1 SHALL load max_count with next count, taking priority over REQ-027.
REQ-029 flush and clear_max together SHALL leave count=0 and max_count=0.

Reset
REQ-030 ap_rst=1 SHALL asynchronously force count=0, max_count=0, pointers=0, out_V_V_TVALID=0, in0_V_V_TREADY=0, almost_full=0, almost_empty=1.
REQ-031 in0_V_V_TREADY SHALL rise no earlier than the first clock edge after ap_rst deasserts.
REQ-032 Reset asserted mid-transfer SHALL discard all contents; no partial write SHALL survive.
REQ-033 Storage array contents need not be reset.

Verification (WIDTH=24, DEPTH=16, AFULL_TH=12, AEMPTY_TH=2)
REQ-034 Fill: write 0x000001..0x000010 with out TREADY=0 -> count=16, TREADY low after 16th, almost_full=1 from count 12, max_count=16.
REQ-035 Drain: after full, out TREADY=1 for 16 cycles -> data 0x000001..0x000010 in order, count 0, TVALID low, almost_empty=1 from count 2.
REQ-036 Wrap: 40 words streamed with both sides valid/ready and random stalls -> output matches input sequence; max_count <= 16.
REQ-037 Full-with-read: count=16, TVALID in and TREADY out both 1 -> count=15 next cycle, no write that cycle.
REQ-038 Flush: count=9, flush 1 cycle -> count=0, TVALID=0, max_count stays 9; subsequent clear_max -> max_count=0.
REQ-039 Async reset: assert ap_rst mid-burst between edges -> outputs reach REQ-030 values before next edge; TREADY low until first edge after deassert.
